// File: rtl/pwm_pkg.sv
// Shared definitions for the LED PWM duty-ramp slice: phase encoding,
// default duty width and the step-sanitising helper.
package pwm_pkg;

    localparam int PWM_WIDTH = 11;
    localparam logic [PWM_WIDTH-1:0] DUTY_MAX = {PWM_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        PH_IDLE     = 3'd0,
        PH_RISE     = 3'd1,
        PH_HOLD_TOP = 3'd2,
        PH_FALL     = 3'd3,
        PH_HOLD_BOT = 3'd4
    } phase_e;

    // A zero step would stall the ramp forever, so it is promoted to one.
    function automatic logic [3:0] eff_step(input logic [3:0] step_in);
        return (step_in == 4'd0) ? 4'd1 : step_in;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler that emits a one-cycle tick every 2^DIV_BITS
// enabled clocks; it freezes together with the ramp when enable is low.
module tick_prescaler #(
    parameter int DIV_BITS = 14
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    logic [DIV_BITS-1:0] count_r;

    // Prescaler count: wraps naturally at all ones.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            count_r <= '0;
        end else if (enable) begin
            count_r <= count_r + {{(DIV_BITS-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    // Gated by enable so a count parked at all ones cannot fire repeatedly.
    assign tick = enable && (count_r == {DIV_BITS{1'b1}});

endmodule

// File: rtl/pwm_duty_ramp.sv
// Triangular breathing duty source with dwell at both extremes, handing
// each new duty word to the PWM comparator over a valid/ready handshake.
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int WIDTH       = PWM_WIDTH,
    parameter int DIV_BITS    = 14,
    parameter int PAUSE_TICKS = 64
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             enable,
    input  logic [3:0]       step,
    output logic [WIDTH-1:0] duty,
    output logic             duty_valid,
    input  logic             duty_ready,
    output logic [2:0]       phase,
    output logic             overrun
);

    localparam logic [WIDTH-1:0] TOP_VAL    = {WIDTH{1'b1}};
    localparam logic [7:0]       PAUSE_LAST = 8'(PAUSE_TICKS - 1);

    logic             tick_s;
    logic [WIDTH:0]   step_s;
    logic [WIDTH:0]   sum_s;
    logic             floor_s;
    logic             stall_s;

    phase_e           phase_r;
    logic [WIDTH-1:0] duty_r;
    logic             duty_valid_r;
    logic             overrun_r;
    logic [7:0]       pause_cnt_r;

    tick_prescaler #(
        .DIV_BITS (DIV_BITS)
    ) u_prescaler (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .enable   (enable),
        .tick     (tick_s)
    );

    // Ramp arithmetic in WIDTH+1 bits so neither direction can wrap.
    always_comb begin
        step_s  = {{(WIDTH-3){1'b0}}, eff_step(step)};
        sum_s   = {1'b0, duty_r} + step_s;
        floor_s = ({1'b0, duty_r} <= step_s);
        stall_s = duty_valid_r && !duty_ready;
    end

    // Ramp FSM, handshake and sticky overrun flag.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            phase_r      <= PH_IDLE;
            duty_r       <= '0;
            duty_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
            pause_cnt_r  <= 8'd0;
        end else begin
            // An accept clears valid; a same-edge reload below re-raises it.
            if (duty_valid_r && duty_ready) begin
                duty_valid_r <= 1'b0;
            end else begin
                duty_valid_r <= duty_valid_r;
            end

            if (tick_s && stall_s) begin
                overrun_r <= 1'b1;
            end else if (tick_s) begin
                case (phase_r)
                    PH_IDLE: begin
                        phase_r <= PH_RISE;
                    end
                    PH_RISE: begin
                        duty_valid_r <= 1'b1;
                        if (sum_s >= {1'b0, TOP_VAL}) begin
                            duty_r  <= TOP_VAL;
                            phase_r <= PH_HOLD_TOP;
                        end else begin
                            duty_r  <= sum_s[WIDTH-1:0];
                        end
                    end
                    PH_HOLD_TOP: begin
                        if (pause_cnt_r == PAUSE_LAST) begin
                            pause_cnt_r <= 8'd0;
                            phase_r     <= PH_FALL;
                        end else begin
                            pause_cnt_r <= pause_cnt_r + 8'd1;
                        end
                    end
                    PH_FALL: begin
                        duty_valid_r <= 1'b1;
                        if (floor_s) begin
                            duty_r  <= '0;
                            phase_r <= PH_HOLD_BOT;
                        end else begin
                            duty_r  <= duty_r - step_s[WIDTH-1:0];
                        end
                    end
                    PH_HOLD_BOT: begin
                        if (pause_cnt_r == PAUSE_LAST) begin
                            pause_cnt_r <= 8'd0;
                            phase_r     <= PH_RISE;
                        end else begin
                            pause_cnt_r <= pause_cnt_r + 8'd1;
                        end
                    end
                    default: begin
                        phase_r     <= PH_IDLE;
                        pause_cnt_r <= 8'd0;
                    end
                endcase
            end else begin
                phase_r <= phase_r;
            end
        end
    end

    assign duty       = duty_r;
    assign duty_valid = duty_valid_r;
    assign phase      = phase_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp with a 16-clock tick period; expected
// values are hand-derived from the ramp arithmetic.
module tb_pwm_duty_ramp;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [3:0]  step = 4'd1;
    logic [10:0] duty;
    logic        duty_valid;
    logic        duty_ready = 1'b1;
    logic [2:0]  phase;
    logic        overrun;

    int checks = 0;
    int failures = 0;
    int since_tick = 0;

    pwm_duty_ramp #(
        .WIDTH       (11),
        .DIV_BITS    (4),
        .PAUSE_TICKS (64)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .enable     (enable),
        .step       (step),
        .duty       (duty),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .phase      (phase),
        .overrun    (overrun)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic clk_edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK_50);
            #1;
            if (enable) since_tick = (since_tick + 1) % 16;
        end
    endtask

    task automatic next_tick();
        clk_edges(16 - since_tick);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) next_tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        since_tick = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (duty !== 11'd0) begin failures++; $display("FAIL reset_duty got=%0d exp=0", duty); end
        checks++; if (duty_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", duty_valid); end
        checks++; if (phase !== 3'd0) begin failures++; $display("FAIL reset_phase got=%0d exp=0", phase); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
    endtask

    task automatic test_first_step();
        clk_edges(15);
        checks++; if (phase !== 3'd0) begin failures++; $display("FAIL pre_tick_phase got=%0d exp=0", phase); end
        clk_edges(1);
        checks++; if (phase !== 3'd1) begin failures++; $display("FAIL first_tick_phase got=%0d exp=1", phase); end
        checks++; if (duty !== 11'd0) begin failures++; $display("FAIL first_tick_duty got=%0d exp=0", duty); end
        next_tick();
        checks++; if (duty !== 11'd1) begin failures++; $display("FAIL second_tick_duty got=%0d exp=1", duty); end
        checks++; if (duty_valid !== 1'b1) begin failures++; $display("FAIL second_tick_valid got=%0b exp=1", duty_valid); end
        clk_edges(1);
        checks++; if (duty_valid !== 1'b0) begin failures++; $display("FAIL valid_pulse_end got=%0b exp=0", duty_valid); end
    endtask

    task automatic test_saturation();
        do_reset();
        step = 4'd15;
        ticks(137);
        checks++; if (duty !== 11'd2040) begin failures++; $display("FAIL rise_2040 got=%0d exp=2040", duty); end
        checks++; if (phase !== 3'd1) begin failures++; $display("FAIL rise_phase got=%0d exp=1", phase); end
        next_tick();
        checks++; if (duty !== 11'd2047) begin failures++; $display("FAIL sat_top got=%0d exp=2047", duty); end
        checks++; if (phase !== 3'd2) begin failures++; $display("FAIL hold_top_phase got=%0d exp=2", phase); end
        checks++; if (duty_valid !== 1'b1) begin failures++; $display("FAIL sat_valid got=%0b exp=1", duty_valid); end
        ticks(63);
        checks++; if (phase !== 3'd2) begin failures++; $display("FAIL hold_63_phase got=%0d exp=2", phase); end
        checks++; if (duty !== 11'd2047) begin failures++; $display("FAIL hold_63_duty got=%0d exp=2047", duty); end
        checks++; if (duty_valid !== 1'b0) begin failures++; $display("FAIL hold_no_valid got=%0b exp=0", duty_valid); end
        next_tick();
        checks++; if (phase !== 3'd3) begin failures++; $display("FAIL hold_64_fall got=%0d exp=3", phase); end
        checks++; if (duty !== 11'd2047) begin failures++; $display("FAIL fall_entry_duty got=%0d exp=2047", duty); end
    endtask

    task automatic test_floor();
        ticks(136);
        checks++; if (duty !== 11'd7) begin failures++; $display("FAIL fall_7 got=%0d exp=7", duty); end
        step = 4'd4;
        next_tick();
        checks++; if (duty !== 11'd3) begin failures++; $display("FAIL fall_3 got=%0d exp=3", duty); end
        checks++; if (phase !== 3'd3) begin failures++; $display("FAIL fall_3_phase got=%0d exp=3", phase); end
        step = 4'd7;
        next_tick();
        checks++; if (duty !== 11'd0) begin failures++; $display("FAIL floor_duty got=%0d exp=0", duty); end
        checks++; if (phase !== 3'd4) begin failures++; $display("FAIL hold_bot_phase got=%0d exp=4", phase); end
        ticks(63);
        checks++; if (phase !== 3'd4) begin failures++; $display("FAIL hold_bot_63 got=%0d exp=4", phase); end
        next_tick();
        checks++; if (phase !== 3'd1) begin failures++; $display("FAIL bot_to_rise got=%0d exp=1", phase); end
        checks++; if (duty !== 11'd0) begin failures++; $display("FAIL bot_to_rise_duty got=%0d exp=0", duty); end
    endtask

    task automatic test_backpressure();
        duty_ready = 1'b0;
        next_tick();
        checks++; if (duty !== 11'd7) begin failures++; $display("FAIL bp_first got=%0d exp=7", duty); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL bp_first_overrun got=%0b exp=0", overrun); end
        ticks(2);
        checks++; if (duty !== 11'd7) begin failures++; $display("FAIL bp_frozen got=%0d exp=7", duty); end
        checks++; if (duty_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_held got=%0b exp=1", duty_valid); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL bp_overrun got=%0b exp=1", overrun); end
        duty_ready = 1'b1;
        clk_edges(1);
        checks++; if (duty_valid !== 1'b0) begin failures++; $display("FAIL bp_accept got=%0b exp=0", duty_valid); end
        next_tick();
        checks++; if (duty !== 11'd14) begin failures++; $display("FAIL bp_resume got=%0d exp=14", duty); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL bp_sticky got=%0b exp=1", overrun); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step = 4'd2;
        duty_ready = 1'b0;
        ticks(2);
        checks++; if (duty !== 11'd2) begin failures++; $display("FAIL b2b_pending got=%0d exp=2", duty); end
        clk_edges(15);
        duty_ready = 1'b1;
        clk_edges(1);
        checks++; if (duty !== 11'd4) begin failures++; $display("FAIL b2b_duty got=%0d exp=4", duty); end
        checks++; if (duty_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%0b exp=1", duty_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%0b exp=0", overrun); end
        clk_edges(1);
        checks++; if (duty_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0b exp=0", duty_valid); end
    endtask

    task automatic test_reset_mid_fall();
        do_reset();
        step = 4'd15;
        ticks(138 + 64 + 69);
        step = 4'd12;
        next_tick();
        checks++; if (duty !== 11'd1000) begin failures++; $display("FAIL fall_1000 got=%0d exp=1000", duty); end
        checks++; if (phase !== 3'd3) begin failures++; $display("FAIL fall_1000_phase got=%0d exp=3", phase); end
        do_reset();
        checks++; if (duty !== 11'd0) begin failures++; $display("FAIL midreset_duty got=%0d exp=0", duty); end
        checks++; if (phase !== 3'd0) begin failures++; $display("FAIL midreset_phase got=%0d exp=0", phase); end
        checks++; if (duty_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid got=%0b exp=0", duty_valid); end
    endtask

    task automatic test_enable_freeze();
        step = 4'd5;
        ticks(3);
        checks++; if (duty !== 11'd10) begin failures++; $display("FAIL pre_freeze got=%0d exp=10", duty); end
        enable = 1'b0;
        clk_edges(1600);
        checks++; if (duty !== 11'd10) begin failures++; $display("FAIL freeze_duty got=%0d exp=10", duty); end
        checks++; if (phase !== 3'd1) begin failures++; $display("FAIL freeze_phase got=%0d exp=1", phase); end
        checks++; if (duty_valid !== 1'b0) begin failures++; $display("FAIL freeze_accept got=%0b exp=0", duty_valid); end
        enable = 1'b1;
        clk_edges(15);
        checks++; if (duty !== 11'd10) begin failures++; $display("FAIL resume_early got=%0d exp=10", duty); end
        clk_edges(1);
        checks++; if (duty !== 11'd15) begin failures++; $display("FAIL resume_tick got=%0d exp=15", duty); end
    endtask

    initial begin
        test_reset();
        test_first_step();
        test_saturation();
        test_floor();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_fall();
        test_enable_freeze();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
